// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline-stage register family.
package pl_pkg;

  localparam logic [31:0] PL_NOP      = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PL_ZEROWORD = 32'h0000_0000;

  // Stage payload widths: four 32-bit PC/instr fields plus a branch flag for IF/ID.
  localparam int unsigned PL_IF_ID_W = 129;
  localparam int unsigned PL_ID_EX_W = 193;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } pl_state_e;

  // Entries held in a given state.
  function automatic logic [1:0] pl_occ(pl_state_e st);
    logic [1:0] occ;
    unique case (st)
      StOne:   occ = 2'd1;
      StTwo:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pl_data_reg.sv
// Payload register: async clear to NOP_VAL, synchronous clear (wins over load), load enable.
module pl_data_reg #(
  parameter int unsigned         DATA_W  = 129,
  parameter logic [DATA_W-1:0]   NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  // Hold, clear to bubble, or capture a new payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= NOP_VAL;
    end else if (clr_i) begin
      data_q <= NOP_VAL;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pl_skid_stage_regs.sv
// Valid/ready pipeline-stage register with optional skid entry and flush-to-bubble.
module pl_skid_stage_regs
  import pl_pkg::*;
#(
  parameter int unsigned       DATA_W  = PL_IF_ID_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(PL_NOP),
  parameter bit                SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
);

  pl_state_e         state_q, state_d;
  logic              up_ready_q, up_ready_d;
  logic              push, pop;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic [DATA_W-1:0] main_src, main_q, skid_q;

  assign dn_valid_o = (state_q != StEmpty);
  assign occ_o      = pl_occ(state_q);
  assign dn_data_o  = main_q;  // main is cleared to NOP_VAL whenever the stage empties
  // Without a skid entry, a full register can only accept alongside a same-cycle pop.
  assign up_ready_o = SKID_EN ? up_ready_q : (dn_ready_i | ~dn_valid_o);
  assign push       = up_valid_i & up_ready_o;
  assign pop        = dn_valid_o & dn_ready_i;

  // Next state, register load/clear strobes and the registered ready.
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_src = up_data_i;
    if (flush_i) begin
      state_d  = StEmpty;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            main_ld = 1'b1;
          end
        end
        StOne: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push && SKID_EN) begin
            state_d = StTwo;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d  = StOne;
            main_ld  = 1'b1;
            main_src = skid_q;
            skid_clr = 1'b1;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    up_ready_d = (state_d != StTwo);
  end

  // State and registered upstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      up_ready_q <= up_ready_d;
    end
  end

  pl_data_reg #(
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (main_clr),
    .ld_i  (main_ld),
    .d_i   (main_src),
    .q_o   (main_q)
  );

  if (SKID_EN) begin : g_skid
    pl_data_reg #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
    ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (skid_clr),
      .ld_i  (skid_ld),
      .d_i   (up_data_i),
      .q_o   (skid_q)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign unused_skid = skid_ld | skid_clr;
    assign skid_q      = NOP_VAL;
  end

endmodule

// File: tb/tb_pl_skid_stage_regs.sv
// Scoreboard bench: accepted pushes are queued, a monitor compares every delivered entry.
module tb_pl_skid_stage_regs;

  localparam int unsigned W = 129;
  localparam logic [W-1:0] NOP = 129'h13;
  localparam logic [W-1:0] VA = 129'h1_0000_000A_0000_00A0_0000_0A00_0000_A000;
  localparam logic [W-1:0] VB = 129'h0_0000_000B_0000_00B0_0000_0B00_0000_B000;
  localparam logic [W-1:0] VC = 129'h1_0000_000C_0000_00C0_0000_0C00_0000_C000;
  localparam logic [W-1:0] VD = 129'h0_DDDD_DDDD_0000_0000_0000_0000_0000_000D;
  localparam logic [W-1:0] VE = 129'h1_EEEE_EEEE_0000_0000_0000_0000_0000_000E;
  localparam logic [W-1:0] VF = 129'h0_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] VG = 129'h1_1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0, up_valid_i = 1'b0, dn_ready_i = 1'b0;
  logic         up_ready_o, dn_valid_o;
  logic [W-1:0] up_data_i = '0, dn_data_o;
  logic [1:0]   occ_o;

  logic         up_valid0 = 1'b0, dn_ready0 = 1'b0, up_ready0, dn_valid0;
  logic [31:0]  up_data0 = '0, dn_data0;
  logic [1:0]   occ0;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pl_skid_stage_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .up_valid_i (up_valid_i),
    .up_ready_o (up_ready_o),
    .up_data_i  (up_data_i),
    .dn_valid_o (dn_valid_o),
    .dn_ready_i (dn_ready_i),
    .dn_data_o  (dn_data_o),
    .occ_o      (occ_o)
  );

  pl_skid_stage_regs #(
    .DATA_W  (32),
    .SKID_EN (1'b0)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (1'b0),
    .up_valid_i (up_valid0),
    .up_ready_o (up_ready0),
    .up_data_i  (up_data0),
    .dn_valid_o (dn_valid0),
    .dn_ready_i (dn_ready0),
    .dn_data_o  (dn_data0),
    .occ_o      (occ0)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
  endfunction

  // Recorder: every accepted push becomes an expected output; flush discards all.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush_i) exp_q.delete();
      else if (up_valid_i && up_ready_o) exp_q.push_back(up_data_i);
    end
  end

  // Monitor: compare each consumed entry and check bubble payload and occupancy bound.
  always @(negedge clk) begin
    if (rst_n && !flush_i) begin
      if (dn_valid_o && dn_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_output", dn_data_o, NOP ^ 129'h1);
        else chk("dn_data", dn_data_o, exp_q.pop_front());
      end else if (!dn_valid_o) begin
        chk("bubble_nop", dn_data_o, NOP);
      end
      chk("occ_le2", W'(occ_o <= 2'd2), W'(1));
    end
  end

  initial begin
    #12 rst_n = 1'b1;
    step();
    chk("rst_valid", W'(dn_valid_o), 0);
    chk("rst_data", dn_data_o, NOP);
    chk("rst_ready", W'(up_ready_o), 1);
    chk("rst_occ", W'(occ_o), 0);

    // Test 1: asynchronous reset mid-cycle with an entry held.
    up_valid_i = 1'b1; up_data_i = VA; dn_ready_i = 1'b0;
    step();
    up_valid_i = 1'b0;
    chk("pre_rst_occ", W'(occ_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(dn_valid_o), 0);
    chk("arst_data", dn_data_o, NOP);
    chk("arst_ready", W'(up_ready_o), 1);
    chk("arst_occ", W'(occ_o), 0);
    rst_n = 1'b1;
    exp_q.delete();
    step();

    // Test 2: streaming with downstream always ready.
    dn_ready_i = 1'b1;
    up_valid_i = 1'b1; up_data_i = VA; step();
    chk("stream_occ_a", W'(occ_o), 1);
    chk("stream_lat_a", dn_data_o, VA);
    up_data_i = VB; step();
    chk("stream_occ_b", W'(occ_o), 1);
    up_data_i = VC; step();
    chk("stream_occ_c", W'(occ_o), 1);
    up_valid_i = 1'b0; step();
    chk("stream_drain_occ", W'(occ_o), 0);

    // Test 3: back-pressure fills the skid, then drains in order without gaps.
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1; up_data_i = VA; step();
    chk("bp_occ1", W'(occ_o), 1);
    chk("bp_ready1", W'(up_ready_o), 1);
    up_data_i = VB; step();
    chk("bp_occ2", W'(occ_o), 2);
    chk("bp_ready2", W'(up_ready_o), 0);
    up_data_i = VC; step();
    chk("bp_hold_occ", W'(occ_o), 2);
    chk("bp_hold_head", dn_data_o, VA);
    dn_ready_i = 1'b1; step();
    chk("bp_pop1_occ", W'(occ_o), 1);
    chk("bp_pop1_head", dn_data_o, VB);
    chk("bp_pop1_ready", W'(up_ready_o), 1);
    step();
    up_valid_i = 1'b0;
    chk("bp_pop2_head", dn_data_o, VC);
    chk("bp_pop2_valid", W'(dn_valid_o), 1);
    step();
    chk("bp_empty_occ", W'(occ_o), 0);

    // Test 4: flush with an offered word while in TWO.
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1; up_data_i = VD; step();
    up_data_i = VE; step();
    chk("fl_pre_occ", W'(occ_o), 2);
    flush_i = 1'b1; up_data_i = VF; step();
    flush_i = 1'b0; up_valid_i = 1'b0;
    chk("fl_valid", W'(dn_valid_o), 0);
    chk("fl_data", dn_data_o, NOP);
    chk("fl_occ", W'(occ_o), 0);
    chk("fl_ready", W'(up_ready_o), 1);
    dn_ready_i = 1'b1;
    up_valid_i = 1'b1; up_data_i = VG; step();
    up_valid_i = 1'b0; step();
    chk("fl_q_empty", W'(exp_q.size()), 0);

    // Test 5: single-register variant.
    up_valid0 = 1'b1; up_data0 = 32'hDEAD_BEEF; dn_ready0 = 1'b0;
    #1 chk("ns_ready_empty", W'(up_ready0), 1);
    step();
    chk("ns_occ", W'(occ0), 1);
    chk("ns_data", W'(dn_data0), W'(32'hDEAD_BEEF));
    chk("ns_ready_full", W'(up_ready0), 0);
    up_data0 = 32'hCAFE_F00D; step();
    chk("ns_hold", W'(dn_data0), W'(32'hDEAD_BEEF));
    dn_ready0 = 1'b1;
    #1 chk("ns_ready_comb", W'(up_ready0), 1);
    step();
    chk("ns_swap_data", W'(dn_data0), W'(32'hCAFE_F00D));
    chk("ns_swap_occ", W'(occ0), 1);
    up_valid0 = 1'b0; step();
    chk("ns_empty_occ", W'(occ0), 0);
    chk("ns_empty_nop", W'(dn_data0), W'(32'h13));

    // Test 6: random valid/ready against the scoreboard; upstream holds data until accepted.
    begin
      logic fire;
      fire = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (!up_valid_i || fire) begin
          up_valid_i = 1'($urandom);
          up_data_i  = up_valid_i ? rnd() : 'x;
        end
        dn_ready_i = 1'($urandom);
        @(negedge clk);
        fire = up_valid_i & up_ready_o;
        step();
      end
    end
    up_valid_i = 1'b0; up_data_i = '0; dn_ready_i = 1'b1;
    repeat (4) step();
    chk("rand_q_empty", W'(exp_q.size()), 0);
    chk("rand_final_occ", W'(occ_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
